bk_timer: RTL

BK_TIMER -- requirements
Module: bk_timer

---
 rtl/bk_timer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/bk_timer.sv
// bk_timer: programmable interval timer with RELOAD/COUNT/CTRL word registers.
// Optional interrupt output and CTRL[8] IEN bit are built when BK_TIMER_IRQ_EN is defined.
`timescale 1ns/1ps
module bk_timer (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce,
  input  logic        ce_tick,
  input  logic [15:0] bus_addr,
  input  logic [15:0] bus_din,
  output logic [15:0] bus_dout,
  input  logic        bus_stb,
  input  logic        bus_we,
  input  logic [1:0]  bus_wtbt,
  input  logic        bus_sync,
  output logic        bus_ack,
  output logic        irq
);

  localparam logic [15:0] ADDR_RELOAD = 16'o177706;
  localparam logic [15:0] ADDR_COUNT  = 16'o177710;
  localparam logic [15:0] ADDR_CTRL   = 16'o177712;

  logic [15:0] reload_q;
  logic [15:0] count_q;
  logic [15:0] rdata;
  logic [7:0]  ctrl_q;
  logic        ien_q;
  logic [12:0] presc_q;
  logic [12:0] presc_last;
  logic        sel_rel;
  logic        sel_cnt;
  logic        sel_ctl;
  logic        sel;
  logic        wr_en;
  logic        tick_en;
  logic        addr_unused;

  // CTRL field aliases
  logic stop, wrap, expen, oneshot, run, div16, div4, expiry;
  assign stop    = ctrl_q[0];
  assign wrap    = ctrl_q[1];
  assign expen   = ctrl_q[2];
  assign oneshot = ctrl_q[3];
  assign run     = ctrl_q[4];
  assign div16   = ctrl_q[5];
  assign div4    = ctrl_q[6];
  assign expiry  = ctrl_q[7];

  assign addr_unused = bus_addr[0];

  assign sel_rel = bus_sync & (bus_addr[15:1] == ADDR_RELOAD[15:1]);
  assign sel_cnt = bus_sync & (bus_addr[15:1] == ADDR_COUNT[15:1]);
  assign sel_ctl = bus_sync & (bus_addr[15:1] == ADDR_CTRL[15:1]);
  assign sel     = sel_rel | sel_cnt | sel_ctl;

  // A write lands only on the ce that raises ack, never while the strobe is held.
  assign wr_en   = ce & bus_stb & sel & bus_we & ~bus_ack;
  assign tick_en = ce_tick & run & ~stop;

  // Prescaler terminal count selected by the divider bits.
  always_comb begin
    presc_last = 13'd127;
    case ({div4, div16})
      2'b01:   presc_last = 13'd2047;
      2'b10:   presc_last = 13'd511;
      2'b11:   presc_last = 13'd8191;
      default: presc_last = 13'd127;
    endcase
  end

  // Register read multiplexer; unselected reads yield zero.
  always_comb begin
    rdata = '0;
    if (sel_rel) rdata = reload_q;
    if (sel_cnt) rdata = count_q;
    if (sel_ctl) rdata = {7'd0, ien_q, ctrl_q};
  end

  // Register writes, prescaler and countdown; a bus write swallows a same-cycle tick.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      reload_q <= '0;
      count_q  <= '0;
      ctrl_q   <= '0;
      presc_q  <= '0;
    end else if (wr_en) begin
      if (sel_rel) begin
        if (bus_wtbt[0]) reload_q[7:0]  <= bus_din[7:0];
        if (bus_wtbt[1]) reload_q[15:8] <= bus_din[15:8];
      end
      if (sel_ctl && bus_wtbt[0]) begin
        ctrl_q  <= {1'b0, bus_din[6:0]};
        presc_q <= '0;
        if (bus_din[4]) count_q <= reload_q;
      end
    end else if (tick_en) begin
      if (presc_q == presc_last) begin
        presc_q <= '0;
        if (count_q != 16'd0) begin
          count_q <= count_q - 16'd1;
        end else begin
          if (expen)   ctrl_q[7] <= 1'b1;
          if (oneshot) ctrl_q[4] <= 1'b0;
          count_q <= wrap ? 16'hFFFF : reload_q;
        end
      end else begin
        presc_q <= presc_q + 13'd1;
      end
    end
  end

  // Bus handshake: ack follows the strobe on ce; read data is registered with it.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      bus_ack  <= 1'b0;
      bus_dout <= '0;
    end else if (ce) begin
      bus_ack  <= bus_stb & (sel | bus_ack);
      bus_dout <= (bus_stb & ~bus_we) ? rdata : '0;
    end
  end

`ifdef BK_TIMER_IRQ_EN
  // Interrupt enable lives in the CTRL high byte.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ien_q <= 1'b0;
    end else if (wr_en && sel_ctl && bus_wtbt[1]) begin
      ien_q <= bus_din[8];
    end
  end

  // Registered interrupt request, held while EXPIRY stays set.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= expiry & ien_q;
    end
  end
`else
  assign ien_q = 1'b0;
  assign irq   = 1'b0;
`endif

endmodule
